// File: rtl/dunc16_mem_resp.sv
// Memory-side responder for the dunc16 CPU bus: word-addressed 16-bit RAM with programmable wait states.
// Define DUNC16_MEM_WRITE_PROTECT_EN to block writes to words 0..ROM_TOP and flag them on WP_ERR.
module dunc16_mem_resp #(
    parameter int ADDR_W      = 8,
    parameter int WAIT_STATES = 1,
    parameter int ROM_TOP     = 15
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        REQ,
    input  logic        WE,
    input  logic [15:0] ADDRESS,
    input  logic [15:0] WDATA,
    output logic [15:0] MMO,
    output logic        ACK,
    output logic        BUSY,
    output logic        WP_ERR
);

    typedef enum logic [1:0] {IDLE, WAIT, ACCESS} state_t;

    state_t              state;
    logic [2:0]          wait_cnt;
    logic [ADDR_W-1:0]   addr_q;
    logic                we_q;
    logic [15:0]         wdata_q;
    logic                write_blocked;
    logic [15:0]         mem [2**ADDR_W];

    // Upper address bits alias away; fold them into a sink so every input bit is consumed.
    logic unused_addr;
    assign unused_addr = ^ADDRESS;

`ifdef DUNC16_MEM_WRITE_PROTECT_EN
    localparam logic [ADDR_W-1:0] ROM_TOP_A = ADDR_W'(ROM_TOP);

    assign write_blocked = (addr_q <= ROM_TOP_A);

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET)
            WP_ERR <= 1'b0;
        else if (state == ACCESS && we_q && write_blocked)
            WP_ERR <= 1'b1;
    end
`else
    logic unused_rom;
    assign unused_rom    = (ROM_TOP != 0);
    assign write_blocked = 1'b0;
    assign WP_ERR        = 1'b0;
`endif

    // Control path: request capture, wait countdown and the completing access.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state    <= IDLE;
            wait_cnt <= 3'd0;
            addr_q   <= '0;
            we_q     <= 1'b0;
            wdata_q  <= 16'h0000;
            MMO      <= 16'h0000;
            ACK      <= 1'b0;
            BUSY     <= 1'b0;
        end else begin
            // NOTE: non-blocking default makes ACK a single-cycle pulse; ACCESS overrides it below.
            ACK <= 1'b0;
            case (state)
                IDLE: begin
                    if (REQ) begin
                        addr_q   <= ADDRESS[ADDR_W-1:0];
                        we_q     <= WE;
                        wdata_q  <= WDATA;
                        wait_cnt <= 3'(WAIT_STATES);
                        BUSY     <= 1'b1;
                        state    <= (WAIT_STATES == 0) ? ACCESS : WAIT;
                    end
                end
                WAIT: begin
                    wait_cnt <= wait_cnt - 3'd1;
                    if (wait_cnt <= 3'd1)
                        state <= ACCESS;
                end
                ACCESS: begin
                    if (!we_q)
                        MMO <= mem[addr_q];
                    ACK   <= 1'b1;
                    BUSY  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // NOTE: the RAM array has no reset; an async reset only returns state to IDLE, so an aborted write never lands.
    always_ff @(posedge CLK) begin
        if (state == ACCESS && we_q && !write_blocked)
            mem[addr_q] <= wdata_q;
    end

endmodule

// File: tb/tb_dunc16_mem_resp.sv
// Scoreboard bench for dunc16_mem_resp: the driver queues expected responses, a monitor checks each ACK.
module tb_dunc16_mem_resp;

    localparam int ADDR_W  = 8;
    localparam int WS      = 1;
    localparam int ROM_TOP = 15;
`ifdef DUNC16_MEM_WRITE_PROTECT_EN
    localparam bit PROT = 1'b1;
`else
    localparam bit PROT = 1'b0;
`endif

    typedef struct {
        logic [15:0] mmo;
        bit          wp;
        bit          must_differ;
        string       name;
    } exp_t;

    logic        CLK;
    logic        RESET;
    logic        REQ;
    logic        WE;
    logic [15:0] ADDRESS;
    logic [15:0] WDATA;
    logic [15:0] MMO;
    logic        ACK;
    logic        BUSY;
    logic        WP_ERR;

    exp_t        exp_q[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    logic [15:0] model_mmo = 16'h0000;
    bit          model_wp  = 1'b0;
    logic        prev_ack  = 1'b0;

    dunc16_mem_resp #(
        .ADDR_W(ADDR_W),
        .WAIT_STATES(WS),
        .ROM_TOP(ROM_TOP)
    ) dut (
        .CLK(CLK),
        .RESET(RESET),
        .REQ(REQ),
        .WE(WE),
        .ADDRESS(ADDRESS),
        .WDATA(WDATA),
        .MMO(MMO),
        .ACK(ACK),
        .BUSY(BUSY),
        .WP_ERR(WP_ERR)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // Monitor: every ACK pops one expectation and compares the response presented with it.
    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            if (RESET === 1'b1 && ACK === 1'b1) begin
                check("ack_not_back_to_back", {31'd0, prev_ack}, 32'd0);
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_ack: got ACK with empty scoreboard, expected none");
                end else begin
                    e = exp_q.pop_front();
                    if (e.must_differ) begin
                        n_checks++;
                        if (MMO !== e.mmo)
                            n_pass++;
                        else
                            $display("FAIL %s_mmo: got %h, required value other than %h", e.name, MMO, e.mmo);
                    end else begin
                        check({e.name, "_mmo"}, {16'd0, MMO}, {16'd0, e.mmo});
                    end
                    check({e.name, "_wp_err"}, {31'd0, WP_ERR}, {31'd0, e.wp});
                    check({e.name, "_busy_low"}, {31'd0, BUSY}, 32'd0);
                end
            end
            prev_ack = (RESET === 1'b1) ? ACK : 1'b0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One complete access: queue the expectation, present REQ for one sampling edge, time the ACK.
    task automatic access(input string name, input bit we, input logic [15:0] addr,
                          input logic [15:0] wd, input logic [15:0] exp_mmo, input bit differ);
        int lat;
        exp_t e;
        e.mmo = exp_mmo; e.wp = model_wp; e.must_differ = differ; e.name = name;
        exp_q.push_back(e);
        @(negedge CLK);
        REQ = 1'b1; WE = we; ADDRESS = addr; WDATA = wd;
        @(posedge CLK);
        #1;
        REQ = 1'b0; WE = ~we; ADDRESS = ~addr; WDATA = ~wd;
        check({name, "_busy_high"}, {31'd0, BUSY}, 32'd1);
        lat = 0;
        do begin
            @(posedge CLK);
            #1;
            lat++;
        end while (ACK !== 1'b1 && lat < 20);
        check({name, "_ack_latency"}, lat, WS + 1);
    endtask

    initial begin
        int acks;
        int first_ack;
        int second_ack;

        RESET = 1'b0; REQ = 1'b1; WE = 1'b1; ADDRESS = 16'h0020; WDATA = 16'hFFFF;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("reset_mmo", {16'd0, MMO}, 32'h0000);
        check("reset_ack", {31'd0, ACK}, 32'd0);
        check("reset_busy", {31'd0, BUSY}, 32'd0);
        check("reset_wp_err", {31'd0, WP_ERR}, 32'd0);
        REQ = 1'b0;
        RESET = 1'b1;

        access("wr_beef", 1'b1, 16'h0020, 16'hBEEF, model_mmo, 1'b0);
        model_mmo = 16'hBEEF;
        access("rd_beef", 1'b0, 16'h0020, 16'h0000, model_mmo, 1'b0);

        access("wr_alias", 1'b1, 16'h0105, 16'h1234, model_mmo, 1'b0);
        model_mmo = 16'h1234;
        access("rd_alias", 1'b0, 16'h0005, 16'h0000, model_mmo, 1'b0);

        access("wr_c0de", 1'b1, 16'h0021, 16'hC0DE, model_mmo, 1'b0);

        // REQ held high across two reads; requests during BUSY must be ignored.
        exp_q.push_back('{16'hBEEF, model_wp, 1'b0, "held_rd20"});
        exp_q.push_back('{16'hC0DE, model_wp, 1'b0, "held_rd21"});
        @(negedge CLK);
        REQ = 1'b1; WE = 1'b0; ADDRESS = 16'h0020; WDATA = 16'h0000;
        acks = 0; first_ack = -1; second_ack = -1;
        for (int k = 0; k <= 2 * WS + 6; k++) begin
            @(posedge CLK);
            #1;
            if (ACK === 1'b1) begin
                acks++;
                if (acks == 1) first_ack = k;
                else second_ack = k;
                ADDRESS = 16'h0021;
            end
            if (k == WS + 2) REQ = 1'b0;
        end
        model_mmo = 16'hC0DE;
        check("held_ack_count", acks, 2);
        check("held_first_ack_edge", first_ack, WS + 1);
        check("held_second_ack_edge", second_ack, 2 * WS + 3);

        access("wr_1111", 1'b1, 16'h0030, 16'h1111, model_mmo, 1'b0);
        model_mmo = 16'h1111;
        access("rd_1111", 1'b0, 16'h0030, 16'h0000, model_mmo, 1'b0);

        // Abort a write in WAIT with reset; the RAM word must keep its old value.
        @(negedge CLK);
        REQ = 1'b1; WE = 1'b1; ADDRESS = 16'h0030; WDATA = 16'hAAAA;
        @(posedge CLK);
        #1;
        REQ = 1'b0;
        check("abort_busy_high", {31'd0, BUSY}, 32'd1);
        #2;
        RESET = 1'b0;
        #1;
        check("abort_busy_cleared", {31'd0, BUSY}, 32'd0);
        check("abort_ack_low", {31'd0, ACK}, 32'd0);
        check("abort_mmo_cleared", {16'd0, MMO}, 32'h0000);
        model_mmo = 16'h0000;
        model_wp  = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        RESET = 1'b1;
        repeat (4) @(posedge CLK);
        access("rd_after_abort", 1'b0, 16'h0030, 16'h0000, 16'h1111, 1'b0);
        model_mmo = 16'h1111;

        access("wr_above_rom", 1'b1, 16'h0010, 16'h6666, model_mmo, 1'b0);
        model_wp = PROT;
        access("wr_rom_0a", 1'b1, 16'h000A, 16'h5555, model_mmo, 1'b0);
        access("wr_rom_top", 1'b1, 16'h000F, 16'h7777, model_mmo, 1'b0);
        access("rd_rom_0a", 1'b0, 16'h000A, 16'h0000, 16'h5555, PROT);
        access("rd_above_rom", 1'b0, 16'h0010, 16'h0000, 16'h6666, 1'b0);

        repeat (5) @(posedge CLK);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
